// File: rtl/vga_disp_pkg.sv
// Shared types, constants and the caption LFSR step for the frame-synchronous
// display blocks.
package vga_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SHOW
  } seq_state_t;

  localparam int H_AV_DEF = 640;
  localparam int V_AV_DEF = 480;

  localparam int                LFSR_W    = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

  localparam int NUM_CAPTIONS = 10;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[3:0], cur[4] ^ cur[2]};
  endfunction

endpackage

// File: rtl/digit_display_sequencer_if.sv
// Digit request channel: the source offers a digit with valid, the sequencer
// answers with ready.
interface digit_display_sequencer_if;

  logic [3:0] digitIn;
  logic       digitValid;
  logic       digitReady;

  modport master (
    output digitIn,
    output digitValid,
    input  digitReady
  );

  modport slave (
    input  digitIn,
    input  digitValid,
    output digitReady
  );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle pulse in the cycle after the pixel counters reach the first pixel of
// vertical blank; the edge detect keeps it to a single pulse per frame.
module frame_tick_gen
  import vga_disp_pkg::*;
#(
  parameter int H_AV = H_AV_DEF,
  parameter int V_AV = V_AV_DEF
) (
  input  logic       pixClk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       vblankTick
);

  logic at_start;
  logic at_start_q;

  // A zero-width line (H_AV of 0) has no first pixel, so it never ticks.
  assign at_start = (x == '0) && (x < 10'(H_AV)) && (y == 10'(V_AV));

  always_ff @(posedge pixClk or posedge reset) begin
    if (reset) begin
      at_start_q <= 1'b0;
      vblankTick <= 1'b0;
    end else begin
      at_start_q <= at_start;
      vblankTick <= at_start && !at_start_q;
    end
  end

endmodule

// File: rtl/digit_display_sequencer.sv
// Commits requested digits to video_gen only at vertical-blank start, picks a
// caption per commit and blanks after a hold time. Optional blink: DIGIT_BLINK_EN.
module digit_display_sequencer
  import vga_disp_pkg::*;
#(
  parameter int H_AV         = H_AV_DEF,
  parameter int V_AV         = V_AV_DEF,
  parameter int HOLD_FRAMES  = 300,
  parameter int BLINK_FRAMES = 60
) (
  input  logic                       pixClk,
  input  logic                       reset,
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
  digit_display_sequencer_if.slave   req,
  output logic [3:0]                 digit,
  output logic                       digitEn,
  output logic [3:0]                 txtSelect,
  output logic                       badDigit
);

  localparam int                HOLD_W    = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);

  seq_state_t        state, state_n;
  logic [3:0]        pending, pending_n;
  logic [3:0]        digit_n, txt_n;
  logic              en_n, bad_n, ready_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n;
  logic [HOLD_W-1:0] holdCnt, hold_n;
  logic              vblankTick;
  logic              accept, take;
`ifdef DIGIT_BLINK_EN
  logic [2:0]        blink_cnt, blink_n;
`endif

  frame_tick_gen #(
    .H_AV (H_AV),
    .V_AV (V_AV)
  ) u_tick (
    .pixClk     (pixClk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .vblankTick (vblankTick)
  );

  assign accept = req.digitValid && req.digitReady;
  assign take   = accept && (req.digitIn <= 4'd9);

  always_ff @(posedge pixClk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pending        <= '0;
      digit          <= '0;
      digitEn        <= 1'b0;
      txtSelect      <= '0;
      badDigit       <= 1'b0;
      req.digitReady <= 1'b0;
      lfsr           <= LFSR_SEED;
      holdCnt        <= '0;
`ifdef DIGIT_BLINK_EN
      blink_cnt      <= '0;
`endif
    end else begin
      state          <= state_n;
      pending        <= pending_n;
      digit          <= digit_n;
      digitEn        <= en_n;
      txtSelect      <= txt_n;
      badDigit       <= bad_n;
      req.digitReady <= ready_n;
      lfsr           <= lfsr_n;
      holdCnt        <= hold_n;
`ifdef DIGIT_BLINK_EN
      blink_cnt      <= blink_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    digit_n   = digit;
    en_n      = digitEn;
    txt_n     = txtSelect;
    lfsr_n    = lfsr;
    hold_n    = holdCnt;
    bad_n     = accept && !take;
`ifdef DIGIT_BLINK_EN
    blink_n   = blink_cnt;
`endif

    unique case (state)
      IDLE: begin
        if (take) begin
          pending_n = req.digitIn;
          state_n   = PENDING;
        end
      end

      PENDING: begin
        if (vblankTick) begin
          digit_n = pending;
          lfsr_n  = lfsr_next(lfsr);
          txt_n   = 4'(lfsr_n % NUM_CAPTIONS);
          hold_n  = HOLD_LOAD;
          en_n    = 1'b1;
          state_n = SHOW;
`ifdef DIGIT_BLINK_EN
          blink_n = '0;
`endif
        end
      end

      SHOW: begin
        // A zero hold count means "hold forever", so only a live count ticks down.
        if (vblankTick && holdCnt != '0) begin
          hold_n = holdCnt - HOLD_W'(1);
          if (holdCnt == HOLD_W'(1)) begin
            if (take) begin
              en_n = 1'b1;
            end else begin
              en_n    = 1'b0;
              state_n = IDLE;
            end
`ifdef DIGIT_BLINK_EN
          end else if (int'(hold_n) == BLINK_FRAMES) begin
            blink_n = '0;
          end else if (int'(holdCnt) <= BLINK_FRAMES) begin
            blink_n = blink_cnt + 3'd1;
            if (blink_cnt == 3'd7) begin
              en_n    = ~digitEn;
              blink_n = '0;
            end
`endif
          end
        end
        if (take) begin
          pending_n = req.digitIn;
          state_n   = PENDING;
        end
      end

      default: state_n = IDLE;
    endcase

    ready_n = (state_n != PENDING);
  end

endmodule

// File: tb/tb_digit_display_sequencer.sv
// Bench for digit_display_sequencer on compressed frames: a frame-level model is
// compared every cycle, plus hand-computed checkpoints along the test plan.
module tb_digit_display_sequencer;

  localparam int HOLD      = 3;
  localparam int FRAME_LEN = 32;
  localparam int V_START   = 480;

  logic       pixClk = 1'b0;
  logic       reset  = 1'b1;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic [3:0] digit;
  logic [3:0] txtSelect;
  logic       digitEn;
  logic       badDigit;

  digit_display_sequencer_if req_bus ();

  digit_display_sequencer #(
    .H_AV         (640),
    .V_AV         (V_START),
    .HOLD_FRAMES  (HOLD),
    .BLINK_FRAMES (60)
  ) dut (
    .pixClk    (pixClk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .req       (req_bus),
    .digit     (digit),
    .digitEn   (digitEn),
    .txtSelect (txtSelect),
    .badDigit  (badDigit)
  );

  always #5 pixClk = ~pixClk;

  int total = 0;
  int bad   = 0;
  int pos   = 1;

  // Frame-level model: a pending digit, a showing flag with frames left, a caption LFSR.
  int m_digit = 0, m_caption = 0, m_lfsr = 1, m_frames_left = 0, m_pend = 0;
  bit m_en = 0, m_ready = 0, m_bad = 0, m_has_pend = 0, m_showing = 0;
  bit m_pulse = 0, m_prev_match = 0;
  bit mm_match, mm_tick, mm_acc, mm_take;

  function automatic void cmp(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge pixClk or posedge reset) begin
    if (reset) begin
      m_digit = 0; m_caption = 0; m_lfsr = 1; m_frames_left = 0; m_pend = 0;
      m_en = 0; m_ready = 0; m_bad = 0; m_has_pend = 0; m_showing = 0;
      m_pulse = 0; m_prev_match = 0;
    end else begin
      mm_match     = (x == 0) && (y == V_START);
      mm_tick      = m_pulse;
      m_pulse      = mm_match && !m_prev_match;
      m_prev_match = mm_match;
      mm_acc       = req_bus.digitValid && m_ready;
      mm_take      = mm_acc && (req_bus.digitIn <= 9);
      m_bad        = mm_acc && !mm_take;
      if (mm_tick) begin
        if (m_has_pend) begin
          m_lfsr        = ((m_lfsr * 2) % 32) + (((m_lfsr / 16) + (m_lfsr / 4)) % 2);
          m_caption     = m_lfsr % 10;
          m_digit       = m_pend;
          m_en          = 1;
          m_showing     = 1;
          m_frames_left = HOLD;
          m_has_pend    = 0;
        end else if (m_showing && m_frames_left > 0) begin
          m_frames_left--;
          if (m_frames_left == 0 && !mm_take) begin
            m_showing = 0;
            m_en      = 0;
          end
        end
      end
      if (mm_take) begin
        m_has_pend = 1;
        m_pend     = int'(req_bus.digitIn);
      end
      m_ready = !m_has_pend;
    end
  end

  always @(negedge pixClk) begin
    cmp("model_digit",     int'(digit),              m_digit);
    cmp("model_digitEn",   int'(digitEn),            int'(m_en));
    cmp("model_txtSelect", int'(txtSelect),          m_caption);
    cmp("model_ready",     int'(req_bus.digitReady), int'(m_ready));
    cmp("model_badDigit",  int'(badDigit),           int'(m_bad));
  end

  task automatic apply_stimulus(input bit valid, input int din);
    req_bus.digitValid = valid;
    req_bus.digitIn    = 4'(din);
  endtask

  task automatic check_output(input string tag, input int e_digit, input int e_en,
                              input int e_txt, input int e_ready);
    cmp({tag, "_digit"}, int'(digit),              e_digit);
    cmp({tag, "_en"},    int'(digitEn),            e_en);
    cmp({tag, "_txt"},   int'(txtSelect),          e_txt);
    cmp({tag, "_ready"}, int'(req_bus.digitReady), e_ready);
  endtask

  task automatic step();
    x = (pos == 0) ? 10'd0 : 10'(pos);
    y = (pos == 0) ? 10'(V_START) : 10'd100;
    @(posedge pixClk);
    #1;
    pos = (pos + 1) % FRAME_LEN;
  endtask

  // Runs through the vblank tick and the commit cycle after it.
  task automatic next_frame();
    while (pos != 0) step();
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    apply_stimulus(0, 0);
    @(posedge pixClk); #1;
    @(posedge pixClk); #1;
    check_output("reset", 0, 0, 0, 0);
    cmp("reset_bad", int'(badDigit), 0);
    #2 reset = 1'b0;
    step();
    check_output("ready_rise", 0, 0, 0, 1);

    $display("[TB] request 7 during active video");
    apply_stimulus(1, 7); step(); apply_stimulus(0, 0);
    check_output("accept_7", 0, 0, 0, 0);
    step(); step();
    check_output("wait_7", 0, 0, 0, 0);
    next_frame(); check_output("commit_7", 7, 1, 2, 1);
    next_frame(); check_output("hold_f1", 7, 1, 2, 1);
    next_frame(); check_output("hold_f2", 7, 1, 2, 1);
    next_frame(); check_output("expire_7", 7, 0, 2, 1);

    $display("[TB] out-of-range request 12");
    apply_stimulus(1, 12); step(); apply_stimulus(0, 0);
    cmp("bad_pulse", int'(badDigit), 1);
    check_output("bad_keep", 7, 0, 2, 1);
    step();
    cmp("bad_clear", int'(badDigit), 0);

    $display("[TB] request aligned to expiry tick");
    apply_stimulus(1, 5); step(); apply_stimulus(0, 0);
    next_frame(); check_output("commit_5", 5, 1, 4, 1);
    next_frame(); next_frame(); check_output("hold_last", 5, 1, 4, 1);
    while (pos != 0) step();
    step();
    apply_stimulus(1, 4); step(); apply_stimulus(0, 0);
    check_output("expiry_override", 5, 1, 4, 0);
    next_frame(); check_output("commit_4", 4, 1, 9, 1);
    next_frame(); next_frame(); check_output("reload_4", 4, 1, 9, 1);
    next_frame(); check_output("expire_4", 4, 0, 9, 1);

    $display("[TB] reset while pending");
    apply_stimulus(1, 6); step(); apply_stimulus(0, 0);
    step(); step();
    #2 reset = 1'b1;
    #1 check_output("reset_mid", 0, 0, 0, 0);
    @(posedge pixClk);
    #2 reset = 1'b0;
    next_frame(); check_output("no_commit", 0, 0, 0, 1);

    $display("[TB] caption sequence 1, 2, 3");
    apply_stimulus(1, 1); step(); apply_stimulus(0, 0);
    next_frame(); check_output("seq_1", 1, 1, 2, 1);
    apply_stimulus(1, 2); step(); apply_stimulus(0, 0);
    step(); step();
    check_output("seq_2_pending", 1, 1, 2, 0);
    next_frame(); check_output("seq_2", 2, 1, 4, 1);
    apply_stimulus(1, 3); step(); apply_stimulus(0, 0);
    next_frame(); check_output("seq_3", 3, 1, 9, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
